// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - command codes, FSM encoding and response lengths for sys_cmd_sequencer
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hAA;
  localparam logic [7:0] CMD_READ    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;

  localparam int OP_A_ADDR = 0;
  localparam int OP_B_ADDR = 1;

  localparam logic [1:0] RESP_LEN_1 = 2'd1;
  localparam logic [1:0] RESP_LEN_2 = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_FUN      = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LO    = 4'd9,
    ST_TX_HI    = 4'd10
  } state_e;

endpackage

// File: rtl/sys_resp_packer.sv
// rtl/sys_resp_packer.sv - 1/2-byte response buffer with FIFO_FULL-aware push, low byte first
module sys_resp_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [1:0]              load_len,
  input  logic [2*DATA_WIDTH-1:0] load_data,
  input  logic                    fifo_full,
  output logic                    push_now,
  output logic                    last_byte,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    fifo_wr_inc
);

  logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_inc_q, wr_inc_d;

  assign push_now     = (cnt_q != 2'd0) && !fifo_full;
  assign last_byte    = (cnt_q == 2'd1);
  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_inc  = wr_inc_q;

  // The buffer shifts down after each push so the next byte is always in the low lane.
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    wr_inc_d  = 1'b0;
    if (load) begin
      buf_d = load_data;
      cnt_d = load_len;
    end else if (push_now) begin
      wr_inc_d  = 1'b1;
      wr_data_d = buf_q[DATA_WIDTH-1:0];
      buf_d     = {{DATA_WIDTH{1'b0}}, buf_q[2*DATA_WIDTH-1:DATA_WIDTH]};
      cnt_d     = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      cnt_q     <= 2'd0;
      wr_data_q <= '0;
      wr_inc_q  <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_inc_q  <= wr_inc_d;
    end
  end

endmodule

// File: rtl/sys_cmd_sequencer.sv
// rtl/sys_cmd_sequencer.sv - UART command parser driving register file, ALU and TX FIFO
// Optional: SYS_CTRL_ERR_RESP_EN answers unknown command bytes with 8'hEE.
module sys_cmd_sequencer
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  input  logic                    FIFO_FULL
);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_d;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic                     rf_rd_en_q, rf_rd_en_d;
  logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
  logic                     alu_en_q, alu_en_d;
  logic                     clk_gate_en_q, clk_gate_en_d;

  logic                     pk_load;
  logic [1:0]               pk_len;
  logic [2*DATA_WIDTH-1:0]  pk_data;
  logic                     pk_push;
  logic                     pk_last;

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_en_q;

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    alu_en_d     = 1'b0;
    pk_load      = 1'b0;
    pk_len       = RESP_LEN_1;
    pk_data      = '0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WRITE)) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_READ)) begin
            state_d = ST_RD_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d = ST_OP_A;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_d = ST_FUN;
          end else begin
`ifdef SYS_CTRL_ERR_RESP_EN
            pk_load = 1'b1;
            pk_data = {{DATA_WIDTH{1'b0}}, DATA_WIDTH'(ERR_BYTE)};
            state_d = ST_TX_LO;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = ST_RD_WAIT;
        end
      end
      // Waiting states ignore RX_D_VLD entirely, so a colliding frame is dropped.
      ST_RD_WAIT: begin
        if (RF_RD_VLD) begin
          pk_load = 1'b1;
          pk_data = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          state_d = ST_TX_LO;
        end
      end
      ST_OP_A: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(OP_A_ADDR);
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (RX_D_VLD) begin
          rf_addr_d    = ADDR_WIDTH'(OP_B_ADDR);
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_FUN;
        end
      end
      ST_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          pk_load = 1'b1;
          pk_len  = RESP_LEN_2;
          pk_data = ALU_OUT;
          state_d = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (pk_push) begin
          state_d = pk_last ? ST_IDLE : ST_TX_HI;
        end
      end
      ST_TX_HI: begin
        if (pk_push) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Follows the next state so the gate opens with CC/DD and closes as ALU_WAIT is left.
    clk_gate_en_d = (state_d == ST_OP_A) || (state_d == ST_OP_B) ||
                    (state_d == ST_FUN)  || (state_d == ST_ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      alu_fun_q     <= '0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_fun_q     <= alu_fun_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
    end
  end

  sys_resp_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_packer (
    .clk          (CLK),
    .rst_n        (RST),
    .load         (pk_load),
    .load_len     (pk_len),
    .load_data    (pk_data),
    .fifo_full    (FIFO_FULL),
    .push_now     (pk_push),
    .last_byte    (pk_last),
    .fifo_wr_data (FIFO_WR_DATA),
    .fifo_wr_inc  (FIFO_WR_INC)
  );

endmodule

// File: tb/tb_sys_cmd_sequencer.sv
// tb/tb_sys_cmd_sequencer.sv - randomized frame-level model check of sys_cmd_sequencer
module tb_sys_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = 8'h00;
  logic        RF_RD_VLD = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic        CLK_GATE_EN;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic        FIFO_FULL = 1'b0;

  always #5 CLK = ~CLK;

  sys_cmd_sequencer #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .ALU_FUN_WIDTH (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RF_ADDR      (RF_ADDR),
    .RF_WR_EN     (RF_WR_EN),
    .RF_RD_EN     (RF_RD_EN),
    .RF_WR_DATA   (RF_WR_DATA),
    .RF_RD_DATA   (RF_RD_DATA),
    .RF_RD_VLD    (RF_RD_VLD),
    .ALU_FUN      (ALU_FUN),
    .ALU_EN       (ALU_EN),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VLD  (ALU_OUT_VLD),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_WR_INC  (FIFO_WR_INC),
    .FIFO_FULL    (FIFO_FULL)
  );

  int checks = 0;
  int failures = 0;

  // Frame-level model: a command is the list of frames collected so far.
  logic [7:0]  frames[$];
  logic [7:0]  txq[$];
  logic [7:0]  mem[16];
  logic        wait_rd = 1'b0, wait_alu = 1'b0, gate = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  logic        e_wr = 1'b0, e_rd = 1'b0, e_alu = 1'b0;
  logic [3:0]  e_addr = 4'h0, e_fun = 4'h0;
  logic [7:0]  e_wdata = 8'h00;
  logic        full_prev = 1'b0;
  int          stall = 0;
  int          full_mode = 2;
  logic [15:0] alu_val = 16'h0000;
  bit          rand_alu = 1'b0;

  logic [7:0]  push_log[$];
  logic [11:0] wr_log[$];
  int          rd_seen = 0;
  int          alu_seen = 0;
  logic [3:0]  last_fun = 4'hF;
  logic [7:0]  script[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit busy();
    return wait_rd || wait_alu || (txq.size() != 0);
  endfunction

  task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
    e_wr    = 1'b1;
    e_addr  = a;
    e_wdata = d;
    mem[a]  = d;
  endtask

  task automatic take_frame(input logic [7:0] b);
    logic [7:0] f0, f1, f2, f3;
    frames.push_back(b);
    f0 = frames[0];
    f1 = (frames.size() > 1) ? frames[1] : 8'h00;
    f2 = (frames.size() > 2) ? frames[2] : 8'h00;
    f3 = (frames.size() > 3) ? frames[3] : 8'h00;
    case (f0)
      8'hAA: if (frames.size() == 3) begin
        model_wr(f1[3:0], f2);
        frames.delete();
      end
      8'hBB: if (frames.size() == 2) begin
        e_rd = 1'b1; e_addr = f1[3:0]; rd_addr = f1[3:0]; wait_rd = 1'b1;
        frames.delete();
      end
      8'hCC: begin
        gate = 1'b1;
        if (frames.size() == 2) model_wr(4'h0, f1);
        if (frames.size() == 3) model_wr(4'h1, f2);
        if (frames.size() == 4) begin
          e_alu = 1'b1; e_fun = f3[3:0]; wait_alu = 1'b1;
          if (rand_alu) alu_val = 16'($urandom);
          frames.delete();
        end
      end
      8'hDD: begin
        gate = 1'b1;
        if (frames.size() == 2) begin
          e_alu = 1'b1; e_fun = f1[3:0]; wait_alu = 1'b1;
          if (rand_alu) alu_val = 16'($urandom);
          frames.delete();
        end
      end
      default: begin
        frames.delete();
`ifdef SYS_CTRL_ERR_RESP_EN
        txq.push_back(8'hEE);
`endif
      end
    endcase
  endtask

  task automatic model_step();
    full_prev = FIFO_FULL;
    e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0;
    if (txq.size() != 0) begin
      // responding: incoming frames are dropped
    end else if (wait_rd) begin
      if (RF_RD_VLD) begin txq.push_back(RF_RD_DATA); wait_rd = 1'b0; end
    end else if (wait_alu) begin
      if (ALU_OUT_VLD) begin
        txq.push_back(ALU_OUT[7:0]); txq.push_back(ALU_OUT[15:8]);
        wait_alu = 1'b0; gate = 1'b0;
      end
    end else if (RX_D_VLD) begin
      take_frame(RX_P_DATA);
    end
  endtask

  task automatic compare();
    chk("rf_wr_en", 32'(RF_WR_EN), 32'(e_wr));
    chk("rf_rd_en", 32'(RF_RD_EN), 32'(e_rd));
    chk("alu_en", 32'(ALU_EN), 32'(e_alu));
    chk("clk_gate_en", 32'(CLK_GATE_EN), 32'(gate));
    if (e_wr) begin
      chk("rf_addr_wr", 32'(RF_ADDR), 32'(e_addr));
      chk("rf_wr_data", 32'(RF_WR_DATA), 32'(e_wdata));
    end
    if (e_rd) chk("rf_addr_rd", 32'(RF_ADDR), 32'(e_addr));
    if (e_alu) chk("alu_fun", 32'(ALU_FUN), 32'(e_fun));
    if (RF_WR_EN) wr_log.push_back({RF_ADDR, RF_WR_DATA});
    if (RF_RD_EN) rd_seen++;
    if (ALU_EN) begin alu_seen++; last_fun = ALU_FUN; end
    if (FIFO_WR_INC) begin
      chk("push_while_full", 32'(full_prev), 32'(0));
      if (txq.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_push: data=%h pending=0 required=no push", FIFO_WR_DATA);
      end else begin
        chk("push_data", 32'(FIFO_WR_DATA), 32'(txq[0]));
        void'(txq.pop_front());
      end
      push_log.push_back(FIFO_WR_DATA);
      stall = 0;
    end else if (txq.size() != 0 && !full_prev) begin
      stall++;
      if (stall > 2) begin
        checks++; failures++;
        $display("FAIL push_stall: pending=%0d pushed=0 required=push with FIFO not full", txq.size());
        stall = 0;
      end
    end else begin
      stall = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
    RX_D_VLD    = 1'b0;
    RF_RD_VLD   = wait_rd && ($urandom_range(0, 2) == 0);
    RF_RD_DATA  = mem[rd_addr];
    ALU_OUT_VLD = wait_alu && ($urandom_range(0, 2) == 0);
    ALU_OUT     = alu_val;
    case (full_mode)
      0: FIFO_FULL = ($urandom_range(0, 3) == 0);
      1: FIFO_FULL = 1'b1;
      default: FIFO_FULL = 1'b0;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (busy() && n < bound) begin tick(); n++; end
    if (busy()) begin
      checks++; failures++;
      $display("FAIL drain_timeout: busy=1 required=0 after %0d cycles", bound);
    end
    tick(); tick();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    RX_D_VLD = 1'b0; RF_RD_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
    #1;
    chk("rst_rf_addr", 32'(RF_ADDR), 32'(0));
    chk("rst_rf_wr_en", 32'(RF_WR_EN), 32'(0));
    chk("rst_rf_rd_en", 32'(RF_RD_EN), 32'(0));
    chk("rst_rf_wr_data", 32'(RF_WR_DATA), 32'(0));
    chk("rst_alu_fun", 32'(ALU_FUN), 32'(0));
    chk("rst_alu_en", 32'(ALU_EN), 32'(0));
    chk("rst_clk_gate_en", 32'(CLK_GATE_EN), 32'(0));
    chk("rst_fifo_wr_data", 32'(FIFO_WR_DATA), 32'(0));
    chk("rst_fifo_wr_inc", 32'(FIFO_WR_INC), 32'(0));
    frames.delete(); txq.delete();
    wait_rd = 1'b0; wait_alu = 1'b0; gate = 1'b0;
    e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0; stall = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic clear_logs();
    push_log.delete(); wr_log.delete();
    rd_seen = 0; alu_seen = 0; last_fun = 4'hF;
  endtask

  task automatic gen_cmd();
    logic [7:0] u;
    case ($urandom_range(0, 4))
      0: begin script.push_back(8'hAA); script.push_back(8'($urandom)); script.push_back(8'($urandom)); end
      1: begin script.push_back(8'hBB); script.push_back(8'($urandom)); end
      2: begin
        script.push_back(8'hCC); script.push_back(8'($urandom));
        script.push_back(8'($urandom)); script.push_back(8'($urandom));
      end
      3: begin script.push_back(8'hDD); script.push_back(8'($urandom)); end
      default: begin
        u = 8'($urandom);
        if (u == 8'hAA || u == 8'hBB || u == 8'hCC || u == 8'hDD) u = 8'h55;
        script.push_back(u);
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #3;
    do_reset();

    // write AA,0B,16
    clear_logs();
    send(8'hAA); send(8'h0B); send(8'h16);
    repeat (3) tick();
    chk("t1_wr_count", 32'(wr_log.size()), 32'(1));
    if (wr_log.size() > 0) chk("t1_wr_addr_data", 32'(wr_log[0]), 32'h0B16);
    chk("t1_no_push", 32'(push_log.size()), 32'(0));

    // read BB,0B
    clear_logs();
    send(8'hBB); send(8'h0B);
    drain(60);
    chk("t2_rd_count", 32'(rd_seen), 32'(1));
    chk("t2_push_count", 32'(push_log.size()), 32'(1));
    if (push_log.size() > 0) chk("t2_push_byte", 32'(push_log[0]), 32'h16);

    // ALU CC,05,03,00 -> 0008
    clear_logs();
    alu_val = 16'h0008;
    send(8'hCC); send(8'h05); send(8'h03); send(8'h00);
    drain(60);
    chk("t3_wr_count", 32'(wr_log.size()), 32'(2));
    if (wr_log.size() > 1) begin
      chk("t3_op_a", 32'(wr_log[0]), 32'h005);
      chk("t3_op_b", 32'(wr_log[1]), 32'h103);
    end
    chk("t3_fun", 32'(last_fun), 32'(0));
    chk("t3_push_count", 32'(push_log.size()), 32'(2));
    if (push_log.size() > 1) begin
      chk("t3_push_lo", 32'(push_log[0]), 32'h08);
      chk("t3_push_hi", 32'(push_log[1]), 32'h00);
    end
    chk("t3_gate_low", 32'(CLK_GATE_EN), 32'(0));

    // DD,02 with FIFO full for 10 cycles
    clear_logs();
    alu_val = 16'hA55A;
    full_mode = 1;
    FIFO_FULL = 1'b1;
    send(8'hDD); send(8'h02);
    repeat (10) tick();
    chk("t4_no_push_full", 32'(push_log.size()), 32'(0));
    full_mode = 2;
    drain(60);
    chk("t4_push_count", 32'(push_log.size()), 32'(2));
    if (push_log.size() > 1) begin
      chk("t4_push_lo", 32'(push_log[0]), 32'h5A);
      chk("t4_push_hi", 32'(push_log[1]), 32'hA5);
    end

    // unknown byte 55
    clear_logs();
    send(8'h55);
    repeat (4) tick();
    chk("t5_no_wr", 32'(wr_log.size() + rd_seen + alu_seen), 32'(0));
`ifdef SYS_CTRL_ERR_RESP_EN
    chk("t5_err_count", 32'(push_log.size()), 32'(1));
    if (push_log.size() > 0) chk("t5_err_byte", 32'(push_log[0]), 32'hEE);
`else
    chk("t5_no_push", 32'(push_log.size()), 32'(0));
`endif

    // reset mid-command, then 16 must be an unknown command
    send(8'hAA); send(8'h0B);
    do_reset();
    clear_logs();
    send(8'h16);
    repeat (4) tick();
    chk("t6_no_wr", 32'(wr_log.size()), 32'(0));
`ifdef SYS_CTRL_ERR_RESP_EN
    chk("t6_err_push", 32'(push_log.size()), 32'(1));
`else
    chk("t6_no_push", 32'(push_log.size()), 32'(0));
`endif

    // randomized traffic with junk frames while busy and a random FIFO_FULL
    full_mode = 0;
    rand_alu = 1'b1;
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        script.delete();
      end else if (!busy()) begin
        if (script.size() == 0) gen_cmd();
        if ($urandom_range(0, 3) != 0) send(script.pop_front());
        else tick();
      end else begin
        if ($urandom_range(0, 4) == 0) send(8'($urandom));
        else tick();
      end
    end
    full_mode = 2;
    drain(100);
    chk("final_tx_empty", 32'(txq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
